piso_shift_reg: RTL and testbench
=================================

// Module: piso_shift_reg
// PURPOSE
//  Parallel-in, serial-out shift register. Transmit-side counterpart of the 4-bit serial-in shift register.
//  Accepts a WIDTH-bit word over a load handshake and drives it out one bit per CLK on OUT.
//  FRAME qualifies OUT, so a downstream SIPO can capture the bits directly.
//  Supports back-to-back words with no idle cycle between them.
// PARAMETERS
//  WIDTH      4   word length in bits; legal range 2..32
//  MSB_FIRST  1   1: send D[WIDTH-1] first; 0: send D[0] first
// PORTS
//  CLK    in   1      clock; all state changes on the rising edge
//  CLR_N  in   1      asynchronous, active-low reset
//  LOAD   in   1      load request; the word is accepted when LOAD & READY at a CLK rise
//  D      in   WIDTH  parallel word; sampled only on an accepted load
//  READY  out  1      block can accept a word this cycle
//  OUT    out  1      serial data; valid only while FRAME=1
//  FRAME  out  1      high for exactly WIDTH cycles per word
//  DONE   out  1      one-cycle pulse, coincident with the last bit of a word
// BEHAVIOUR
//  Reset (CLR_N=0, asynchronous, any time, including mid-word):
//   - state=IDLE, shift reg=0, cnt=0.
//   - Outputs: OUT=0, FRAME=0, DONE=0, READY=1 (READY becomes valid once CLR_N=1).
//   - A word in flight is discarded and no DONE is produced.
//  FSM has 2 states:
//   - IDLE -> SHIFT on an accepted load.
//   - SHIFT -> IDLE when cnt==0 and no load is accepted.
//   - SHIFT -> SHIFT (reload) when cnt==0 and a load is accepted.
//  Outputs are decoded from registered state:
//   - READY = (state==IDLE) | (state==SHIFT & cnt==0)
//   - FRAME = (state==SHIFT)
//   - DONE  = (state==SHIFT & cnt==0)
//   - OUT   = FRAME ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 0
//  Accept edge: sreg<=D, cnt<=WIDTH-1, state<=SHIFT.
//   - First bit appears on OUT in the cycle after the accept edge (latency 1).
//  Each SHIFT edge with cnt!=0:
//   - cnt<=cnt-1.
//   - sreg shifts toward the output end (left if MSB_FIRST, else right), filling with 0.
//  Last-bit cycle (cnt==0):
//   - Load accepted: reload as above. FRAME stays 1 and the next word's first bit follows with zero gap.
//   - Otherwise: return to IDLE; FRAME=0 next cycle.
//  LOAD while READY=0 is ignored. It is not queued, and D is not sampled.
//  D changing during SHIFT has no effect on the word in flight.
//  cnt width is $clog2(WIDTH). WIDTH bits per word exactly; no wrap beyond WIDTH-1.
//  X on LOAD during reset is don't-care.
// STRUCTURE
//  Shared include shift_reg_defs.vh holds:
//   - state encodings `SR_IDLE=1'b0, `SR_SHIFT=1'b1
//   - default width `SR_WIDTH=4 (shared with the SIPO)
//  One natural sub-module: bit_counter (load value, decrement enable, zero flag, async active-low clear).
//   - The FSM, shift register and output decode stay in piso_shift_reg.
// TESTING (WIDTH=4 unless noted; CLK period 10 ns)
//  1. Reset: hold CLR_N=0 for 2 cycles -> READY=1, OUT=0, FRAME=0, DONE=0. Release: stays IDLE with LOAD=0.
//  2. Single word, MSB_FIRST=1: D=4'b1011, LOAD for 1 cycle.
//     -> Next 4 cycles: OUT=1,0,1,1; FRAME=1; DONE on the 4th only. Then FRAME=0, READY=1.
//  3. LSB first, MSB_FIRST=0: D=4'b1011 -> OUT=1,1,0,1.
//  4. Back-to-back: D=4'hA accepted, then LOAD with D=4'h5 held on the last-bit cycle.
//     -> OUT=1,0,1,0,0,1,0,1 with FRAME continuously 1 for 8 cycles; DONE on cycles 4 and 8.
//  5. Ignored load: LOAD=1 with D=4'hF on bit cycles 1-3 of word 4'h9.
//     -> OUT=1,0,0,1 unchanged; word 4'hF is accepted only on the last-bit cycle.
//  6. Reset mid-word: CLR_N=0 asynchronously after bit 2 of 4'hC.
//     -> OUT, FRAME and DONE go 0 immediately with no DONE pulse; the next word 4'h3 transmits cleanly as 0,0,1,1.
//  Scoreboard: model a SIPO capturing OUT while FRAME=1 and compare each captured word to the accepted D.
//   - Also check the invariants: DONE implies FRAME, and READY=1 whenever state==IDLE.

Source files
------------

// File: rtl/piso_shift_reg_pkg.sv
// Shared definitions for the PISO shift register: state encoding and default word width.
package piso_shift_reg_pkg;

   localparam int unsigned SR_WIDTH = 4;

   typedef enum logic {
      SR_IDLE  = 1'b0,
      SR_SHIFT = 1'b1
   } sr_state_e;

   // Bit-count register width for a given word length (never below 1 bit).
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/piso_shift_reg_bit_counter.sv
// Down-counter of remaining bits in a word: parallel load, decrement, and a zero flag
// that is available both registered and as its next-cycle value.
module piso_shift_reg_bit_counter #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         dec,
   output logic         zero,
   output logic         zero_nxt_c
);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;

   // Decrement is suppressed at zero so the count never wraps.
   always_comb begin
      cnt_nxt    = cnt;
      zero_nxt_c = zero;
      if (ld) begin
         cnt_nxt    = ld_val;
         zero_nxt_c = (ld_val == '0);
      end else if (dec && !zero) begin
         cnt_nxt    = cnt - W'(1);
         zero_nxt_c = (cnt == W'(1));
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt  <= '0;
         zero <= 1'b1;
      end else begin
         cnt  <= cnt_nxt;
         zero <= zero_nxt_c;
      end
   end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with load handshake, FRAME qualifier and
// DONE pulse on the last bit; back-to-back words are sent with no idle gap.
module piso_shift_reg
   import piso_shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH     = SR_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic             ready,
   output logic             out,
   output logic             frame,
   output logic             done
);

   localparam int unsigned CW = cnt_width(WIDTH);

   sr_state_e        state;
   sr_state_e        state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nxt;
   logic             accept_c;
   logic             ld_c;
   logic             shift_c;
   logic             cnt_zero;
   logic             cnt_zero_nxt_c;
   logic             ready_nxt;
   logic             frame_nxt;
   logic             done_nxt;
   logic             out_nxt;

   piso_shift_reg_bit_counter #(
      .W (CW)
   ) u_bit_counter (
      .clk        (clk),
      .clr_n      (clr_n),
      .ld         (ld_c),
      .ld_val     (CW'(WIDTH - 1)),
      .dec        (shift_c),
      .zero       (cnt_zero),
      .zero_nxt_c (cnt_zero_nxt_c)
   );

   // Next state, shift-register update, and next values of the registered outputs.
   always_comb begin
      state_nxt = state;
      ld_c      = 1'b0;
      shift_c   = 1'b0;
      sreg_nxt  = sreg;
      accept_c  = load & ready;

      case (state)
         SR_IDLE: begin
            if (accept_c) begin
               ld_c      = 1'b1;
               state_nxt = SR_SHIFT;
            end
         end
         SR_SHIFT: begin
            if (!cnt_zero) begin
               shift_c = 1'b1;
            end else if (accept_c) begin
               ld_c = 1'b1;
            end else begin
               state_nxt = SR_IDLE;
            end
         end
         default: state_nxt = SR_IDLE;
      endcase

      if (ld_c) begin
         sreg_nxt = d;
      end else if (shift_c) begin
         if (MSB_FIRST) sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
         else           sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
      end

      // Outputs are registered, so decode them from the next-cycle state.
      frame_nxt = (state_nxt == SR_SHIFT);
      done_nxt  = frame_nxt & cnt_zero_nxt_c;
      ready_nxt = !frame_nxt | done_nxt;
      out_nxt   = frame_nxt & (MSB_FIRST ? sreg_nxt[WIDTH-1] : sreg_nxt[0]);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= SR_IDLE;
         sreg  <= '0;
         ready <= 1'b1;
         frame <= 1'b0;
         done  <= 1'b0;
         out   <= 1'b0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         ready <= ready_nxt;
         frame <= frame_nxt;
         done  <= done_nxt;
         out   <= out_nxt;
      end
   end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Scoreboard bench for piso_shift_reg: MSB-first and LSB-first instances share stimulus;
// a SIPO-style monitor rebuilds each word from OUT while FRAME=1.
module tb_piso_shift_reg;

   localparam int unsigned W = 4;

   logic         clk;
   logic         clr_n;
   logic         load;
   logic [W-1:0] d;

   logic ready_m, out_m, frame_m, done_m;
   logic ready_l, out_l, frame_l, done_l;

   piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk   (clk),
      .clr_n (clr_n),
      .load  (load),
      .d     (d),
      .ready (ready_m),
      .out   (out_m),
      .frame (frame_m),
      .done  (done_m)
   );

   piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk   (clk),
      .clr_n (clr_n),
      .load  (load),
      .d     (d),
      .ready (ready_l),
      .out   (out_l),
      .frame (frame_l),
      .done  (done_l)
   );

   logic [1:0] rdy, ob, fr, dn;
   assign rdy = {ready_l, ready_m};
   assign ob  = {out_l,   out_m};
   assign fr  = {frame_l, frame_m};
   assign dn  = {done_l,  done_m};

   int checks = 0;
   int errors = 0;

   // Expected words, one queue per instance.
   logic [W-1:0] q_m [$];
   logic [W-1:0] q_l [$];

   // Reference model: number of bit cycles still to show, including the current one.
   int rem = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // One stimulus cycle at the falling edge: check handshake outputs against the model,
   // drive inputs, and record any word the model says will be accepted.
   task automatic cycle(input logic ld, input logic [W-1:0] dv);
      logic acc;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk(k == 0 ? "ready_msb" : "ready_lsb", 32'(rdy[k]), 32'(rem <= 1));
         chk(k == 0 ? "frame_msb" : "frame_lsb", 32'(fr[k]),  32'(rem > 0));
         chk(k == 0 ? "done_msb"  : "done_lsb",  32'(dn[k]),  32'(rem == 1));
      end
      load = ld;
      d    = dv;
      acc  = ld && (rem <= 1);
      if (acc) begin
         q_m.push_back(dv);
         q_l.push_back(dv);
         rem = W;
      end else if (rem > 0) begin
         rem = rem - 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom));
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
   task automatic async_reset();
      #2 clr_n = 1'b0;
      load = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_out",   32'(ob[k]),  32'd0);
         chk("rst_frame", 32'(fr[k]),  32'd0);
         chk("rst_done",  32'(dn[k]),  32'd0);
         chk("rst_ready", 32'(rdy[k]), 32'd1);
      end
      q_m.delete();
      q_l.delete();
      rem = 0;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
   endtask

   // SIPO monitor: rebuilds each word from OUT while FRAME=1 and compares with the queue.
   initial begin : monitor
      int           cap_cnt [2];
      logic [W-1:0] cap [2];
      logic [W-1:0] exp_w;
      cap_cnt = '{0, 0};
      cap     = '{'0, '0};
      forever begin
         @(negedge clk);
         if (!clr_n) begin
            cap_cnt = '{0, 0};
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (fr[k]) begin
                  if (k == 0) cap[k] = {cap[k][W-2:0], ob[k]};
                  else        cap[k] = {ob[k], cap[k][W-1:1]};
                  cap_cnt[k]++;
                  if (cap_cnt[k] == W) begin
                     chk("done_on_last_bit", 32'(dn[k]), 32'd1);
                     if (k == 0) begin
                        chk("sb_word_expected_msb", 32'(q_m.size() != 0), 32'd1);
                        if (q_m.size() != 0) begin
                           exp_w = q_m.pop_front();
                           chk("word_msb", 32'(cap[k]), 32'(exp_w));
                        end
                     end else begin
                        chk("sb_word_expected_lsb", 32'(q_l.size() != 0), 32'd1);
                        if (q_l.size() != 0) begin
                           exp_w = q_l.pop_front();
                           chk("word_lsb", 32'(cap[k]), 32'(exp_w));
                        end
                     end
                     cap_cnt[k] = 0;
                  end else begin
                     chk("done_early", 32'(dn[k]), 32'd0);
                  end
               end else begin
                  chk("done_implies_frame", 32'(dn[k]), 32'd0);
                  chk("out_idle_zero",      32'(ob[k]), 32'd0);
                  chk("frame_gap_midword",  32'(cap_cnt[k]), 32'd0);
                  cap_cnt[k] = 0;
               end
            end
         end
      end
   end

   initial begin
      clr_n = 1'b1;
      load  = 1'b0;
      d     = '0;
      #1 clr_n = 1'b0;

      // Reset held for two cycles.
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_ready", 32'(rdy[k]), 32'd1);
         chk("reset_out",   32'(ob[k]),  32'd0);
         chk("reset_frame", 32'(fr[k]),  32'd0);
         chk("reset_done",  32'(dn[k]),  32'd0);
      end
      clr_n = 1'b1;
      idle(3);

      // Single word 1011.
      cycle(1'b1, 4'b1011);
      idle(6);

      // Back-to-back A then 5, second load on the last-bit cycle.
      cycle(1'b1, 4'hA);
      idle(3);
      cycle(1'b1, 4'h5);
      idle(6);

      // Loads during bits 1-3 of 9 are ignored; F is taken on the last bit.
      cycle(1'b1, 4'h9);
      repeat (4) cycle(1'b1, 4'hF);
      idle(6);

      // Reset in the middle of C, then 3 transmits cleanly.
      cycle(1'b1, 4'hC);
      idle(2);
      async_reset();
      cycle(1'b1, 4'h3);
      idle(6);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) cycle(1'(($urandom_range(0, 3)) != 0), W'($urandom));
      idle(8);

      chk("queue_drained_msb", 32'(q_m.size()), 32'd0);
      chk("queue_drained_lsb", 32'(q_l.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
